logic_gate_unit: RTL and testbench
==================================

// Module: logic_gate_unit
// PURPOSE
//  Parametrised, registered successor to the single-bit AND/NOT/NAND primitives.
//  Applies one of eight bitwise gate ops to two WIDTH-bit operands per transaction.
//  Buffers results in a DEPTH-entry FIFO behind valid/ready handshakes.
//  Sits between a stimulus or bus front-end and any consumer of gate results.
// PARAMETERS
//  WIDTH  8   operand/result width in bits (>=1)
//  DEPTH  4   result FIFO entries (power of 2, >=2)
//  CNT_W  16  width of accepted-transaction counter
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               async active-low reset
//  in_valid   in   1               operands/op valid
//  in_ready   out  1               unit can accept (FIFO not full)
//  op         in   3               gate select, see BEHAVIOUR
//  a          in   WIDTH           operand A
//  b          in   WIDTH           operand B
//  out_valid  out  1               FIFO head valid (FIFO not empty)
//  out_ready  in   1               consumer accepts head
//  y          out  WIDTH           FIFO head result
//  level      out  $clog2(DEPTH)+1 current FIFO occupancy
//  acc_cnt    out  CNT_W           accepted transactions, saturating
// BEHAVIOUR
//  - Reset: one clock; reset is asynchronous, active-low (rst_n).
//    Asserting rst_n=0 at any time, including mid-transfer, immediately clears
//    FIFO pointers, level=0, out_valid=0, y=0, acc_cnt=0, in_ready=1.
//    Unpopped entries are discarded.
//  - Op encoding (bitwise):
//    000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR,
//    110 NOT a (b ignored), 111 BUF a.
//  - Accept (push): in_valid & in_ready at a rising edge.
//    Result f(op,a,b) is computed combinationally and written to the tail.
//  - Pop: out_valid & out_ready at a rising edge; head advances.
//  - in_ready = (level != DEPTH). out_valid = (level != 0).
//    Both are pure functions of registered state (no combinational in->out path).
//  - Latency: push at edge N into an empty FIFO -> out_valid=1, y valid after edge N.
//  - Simultaneous push & pop: allowed when 0 < level < DEPTH; level is unchanged.
//    Full: in_ready=0, so no push even if pop occurs the same cycle.
//    Empty: pop is impossible, so a push alone raises level to 1.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - y is driven from the head entry; holds while out_valid & !out_ready.
//    y is 0 when empty.
//  - acc_cnt increments by 1 per push; saturates at 2^CNT_W-1, never wraps.
//  - Inputs are ignored when in_valid=0 or in_ready=0; op/a/b are don't-care then.
// CONFIGURATION
//  LGU_PARITY_EN defined:
//    adds output port y_par (1 bit) = ^y (even-parity bit of head result).
//    y_par is stored per entry alongside the result; 0 at reset and when empty.
//  LGU_PARITY_EN undefined:
//    no y_par port, no parity storage; all other behaviour identical.
// TESTING
//  1 Reset: rst_n=0 -> in_ready=1, out_valid=0, y=0, level=0, acc_cnt=0.
//  2 Ops, WIDTH=8, a=8'hF0, b=8'hCC, one push per op 000..111, out_ready=1:
//    y = C0, FC, 3F, 03, 3C, C3, 0F, F0 in order; each 1 cycle after push.
//  3 Fill: out_ready=0, 4 pushes -> level=4, in_ready=0.
//    5th in_valid is held off. Then out_ready=1 pops entries in push order.
//  4 Concurrent: level=2, push and pop together for 10 cycles.
//    level stays 2; results remain in order across pointer wrap.
//  5 Async reset mid-stream: level=3, drop rst_n between edges.
//    Outputs clear immediately; the first push after release appears as the head.
//  6 Saturation with CNT_W=4: 20 pushes -> acc_cnt=15.
//    With LGU_PARITY_EN: y=8'h07 -> y_par=1.

Source files
------------

// File: rtl/logic_gate_unit.sv
// -----------------------------------------------------------------------------
// logic_gate_unit
//
// Purpose:
//   Applies one of eight bitwise gate operations to two WIDTH-bit operands.
//   Results are buffered in a DEPTH-entry FIFO that sits between valid/ready
//   handshakes on its input and output sides. A saturating counter records
//   how many transactions have been accepted.
//
// Handshake rule (both sides):
//   A beat transfers on a rising clk edge where valid and ready are both high.
//   in_ready and out_valid come only from registered state (level_q), so there
//   is no combinational path from any input to any output. Once valid is
//   raised, the producer holds it and its payload until the beat transfers.
//
// Parameters:
//   WIDTH  operand/result width (>=1)
//   DEPTH  FIFO entries (power of 2, >=2)
//   CNT_W  accepted-transaction counter width
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/op valid
//   in_ready   FIFO not full
//   op         gate select: 000 AND, 001 OR, 010 NAND, 011 NOR,
//              100 XOR, 101 XNOR, 110 NOT a, 111 BUF a
//   a, b       operands
//   out_valid  FIFO not empty
//   out_ready  consumer accepts head
//   y          head result (0 when empty)
//   level      FIFO occupancy
//   acc_cnt    accepted transactions, saturating
//   y_par      even-parity bit of y (only with LGU_PARITY_EN)
//
// Configuration macro:
//   LGU_PARITY_EN  adds y_par plus a per-entry parity bit
// -----------------------------------------------------------------------------
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           y,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           acc_cnt
`ifdef LGU_PARITY_EN
    ,
    output logic                       y_par
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    // Gate function, evaluated on the live operands and written at the tail.
    always_comb begin
        result = '0;
        unique case (op)
            3'b000:  result = a & b;
            3'b001:  result = a | b;
            3'b010:  result = ~(a & b);
            3'b011:  result = ~(a | b);
            3'b100:  result = a ^ b;
            3'b101:  result = ~(a ^ b);
            3'b110:  result = ~a;
            default: result = a;
        endcase
    end

    assign in_ready  = (level_q != LVL_FULL);
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        // Pointers are exactly PTR_W bits, so the increment wraps modulo DEPTH.
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // Saturate: stop counting once every bit is set.
        if (push && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: y and y_par are forced to 0 while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= result;
    end

    assign y       = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level   = level_q;
    assign acc_cnt = cnt_q;

`ifdef LGU_PARITY_EN
    logic par_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push) par_q[wr_ptr_q] <= ^result;
    end

    assign y_par = out_valid ? par_q[rd_ptr_q] : 1'b0;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
module tb_logic_gate_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [2:0]       level;
  logic [CNT_W-1:0] acc_cnt;
`ifdef LGU_PARITY_EN
  logic             y_par;
`endif

  logic [WIDTH-1:0] exp_q[$];
  int n_chk;
  int n_fail;

  logic_gate_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .level     (level),
    .acc_cnt   (acc_cnt)
`ifdef LGU_PARITY_EN
    ,
    .y_par     (y_par)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: present one beat, hold until accepted, record expected result
  task automatic push(input logic [2:0] p_op, input logic [7:0] p_a, input logic [7:0] p_b,
                      input logic [7:0] p_exp);
    bit ok;
    op = p_op;
    a = p_a;
    b = p_b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stayed 0 for op %0d a %0h", p_op, p_a);
    end else begin
      exp_q.push_back(p_exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: each popped head is compared to the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got y %0h with empty expected queue", y);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (y !== e) begin
          n_fail++;
          $display("FAIL pop_data: got y %0h expected %0h", y, e);
        end
      end
    end
  end

  logic [7:0] op_exp [8];
  logic [7:0] cc_exp [12];
  logic [7:0] cc_a   [12];

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;
    op_exp = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    cc_a   = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
               8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};
    cc_exp = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A,
               8'h69, 8'h78, 8'h87, 8'h96, 8'hA5, 8'hB4};

    // 1 reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);
`ifdef LGU_PARITY_EN
    chk("rst_y_par", 32'(y_par), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 2 all eight ops, visible one cycle after push
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(3'(i), 8'hF0, 8'hCC, op_exp[i]);
      chk("op_latency_valid", 32'(out_valid), 32'd1);
    end
    idle(3);
    chk("op_drained", 32'(level), 32'd0);

    // 3 fill, hold off, drain in order
    out_ready = 1'b0;
    push(3'b000, 8'h01, 8'hFF, 8'h01);
    push(3'b000, 8'h02, 8'hFF, 8'h02);
    push(3'b000, 8'h04, 8'hFF, 8'h04);
    push(3'b000, 8'h08, 8'hFF, 8'h08);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_head_hold", 32'(y), 32'h01);
    op = 3'b001;
    a = 8'h10;
    b = 8'h00;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("holdoff_in_ready", 32'(in_ready), 32'd0);
      chk("holdoff_level", 32'(level), 32'd4);
      chk("holdoff_head", 32'(y), 32'h01);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    push(3'b001, 8'h10, 8'h00, 8'h10);
    idle(8);
    chk("fill_drained", 32'(level), 32'd0);

    // 4 concurrent push/pop at level 2 across pointer wrap
    out_ready = 1'b0;
    push(3'b100, cc_a[0], 8'h0F, cc_exp[0]);
    push(3'b100, cc_a[1], 8'h0F, cc_exp[1]);
    chk("cc_prefill_level", 32'(level), 32'd2);
    out_ready = 1'b1;
    fork
      begin
        for (int i = 2; i < 12; i++) push(3'b100, cc_a[i], 8'h0F, cc_exp[i]);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          chk("cc_level", 32'(level), 32'd2);
        end
      end
    join
    idle(6);
    chk("cc_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("cc_drained", 32'(level), 32'd0);

    // 5 async reset mid-stream
    out_ready = 1'b0;
    push(3'b000, 8'hFF, 8'h11, 8'h11);
    push(3'b000, 8'hFF, 8'h22, 8'h22);
    push(3'b000, 8'hFF, 8'h33, 8'h33);
    chk("ar_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_y", 32'(y), 32'd0);
    chk("ar_level0", 32'(level), 32'd0);
    chk("ar_acc_cnt", 32'(acc_cnt), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    idle(1);
    push(3'b000, 8'hFF, 8'h5A, 8'h5A);
    chk("ar_new_level", 32'(level), 32'd1);
    chk("ar_new_head", 32'(y), 32'h5A);
    chk("ar_new_cnt", 32'(acc_cnt), 32'd1);
    out_ready = 1'b1;
    idle(3);

    // 6 counter saturation at 2^CNT_W-1
    rst_n = 1'b0;
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    idle(1);
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      push(3'b111, 8'(i), 8'h00, 8'(i));
      if (i == 14) chk("sat_cnt14", 32'(acc_cnt), 32'd14);
      if (i == 15) chk("sat_cnt15", 32'(acc_cnt), 32'd15);
    end
    chk("sat_cnt20", 32'(acc_cnt), 32'd15);
    idle(3);
`ifdef LGU_PARITY_EN
    out_ready = 1'b0;
    chk("par_empty", 32'(y_par), 32'd0);
    push(3'b111, 8'h07, 8'h00, 8'h07);
    chk("par_07", 32'(y_par), 32'd1);
    out_ready = 1'b1;
    idle(3);
`endif
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_level", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_chk, n_fail);
    $fatal(1);
  end

endmodule
